apb_modport: RTL and testbench

APB_MODPORT -- requirements
Module: apb_modport

---
 rtl/apb_modport_if.sv | 34 +++
 rtl/apb_modport.sv | 100 ++++++++++
 tb/tb_apb_modport.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_modport_if.sv
// Request/response bundle between a transfer requester and the apb_modport block.
// The requester uses the master modport; apb_modport uses the slave modport.
interface apb_modport_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
);
    logic                  transfer;
    logic                  READ_WRITE;
    logic [ADDR_WIDTH-1:0] apb_write_paddr;
    logic [DATA_WIDTH-1:0] apb_write_data;
    logic [ADDR_WIDTH-1:0] apb_read_paddr;
    logic [DATA_WIDTH-1:0] apb_read_data_out;
    logic                  PSLVERR;

    modport master (
        output transfer,
        output READ_WRITE,
        output apb_write_paddr,
        output apb_write_data,
        output apb_read_paddr,
        input  apb_read_data_out,
        input  PSLVERR
    );

    modport slave (
        input  transfer,
        input  READ_WRITE,
        input  apb_write_paddr,
        input  apb_write_data,
        input  apb_read_paddr,
        output apb_read_data_out,
        output PSLVERR
    );
endinterface

// File: rtl/apb_modport.sv
// APB master FSM driving two internal zero-wait-state slaves, each 64 words deep.
// Address bit 8 picks the slave, bits 7:6 must be 00, bits 5:0 index the word.
module apb_modport #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    apb_modport_if.slave bus
);
    localparam int MEM_DEPTH = 64;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_pslverr;
    logic [DATA_WIDTH-1:0] r_mem1 [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem2 [MEM_DEPTH];

    logic                  w_psel;
    logic                  w_penable;
    logic                  w_pwrite;
    logic                  w_pready;
    logic                  w_complete;
    logic                  w_err;
    logic                  w_sel2;
    logic                  w_start;
    logic [5:0]            w_index;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_psel      = (r_state != S_IDLE);
    assign w_penable   = (r_state == S_ACCESS);
    assign w_pwrite    = ~r_rw;
    assign w_pready    = 1'b1;
    assign w_complete  = w_psel & w_penable & w_pready;
    assign w_err       = |r_addr[7:6];
    assign w_sel2      = r_addr[8];
    assign w_index     = r_addr[5:0];
    assign w_rd_word   = w_sel2 ? r_mem2[w_index] : r_mem1[w_index];
    assign w_next_addr = bus.READ_WRITE ? bus.apb_read_paddr : bus.apb_write_paddr;

    // A new request is captured on every edge that enters SETUP, from IDLE or from a completing ACCESS.
    assign w_start = bus.transfer & ((r_state == S_IDLE) | ((r_state == S_ACCESS) & w_pready));

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= S_IDLE;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_pslverr <= 1'b0;
        end else begin
            r_pslverr <= 1'b0;
            if (w_start) begin
                r_rw    <= bus.READ_WRITE;
                r_addr  <= w_next_addr;
                r_wdata <= bus.apb_write_data;
            end
            if (w_complete && !w_pwrite) begin
                r_rdata <= w_err ? '0 : w_rd_word;
            end
            case (r_state)
                S_IDLE:   if (bus.transfer) r_state <= S_SETUP;
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_pslverr <= w_err;
                end
                S_ACCESS: r_state <= bus.transfer ? S_SETUP : S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the memories are cleared by reset because a reset must leave every stored word reading back 0.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem1[i] <= '0;
                r_mem2[i] <= '0;
            end
        end else if (w_complete && w_pwrite && !w_err) begin
            if (w_sel2) r_mem2[w_index] <= r_wdata;
            else        r_mem1[w_index] <= r_wdata;
        end
    end

    assign bus.apb_read_data_out = r_rdata;
    assign bus.PSLVERR           = r_pslverr;
endmodule

// File: tb/tb_apb_modport.sv
// Self-checking bench for apb_modport: directed scenarios plus randomized single and
// back-to-back transfers checked against a word-array model of the two slaves.
module tb_apb_modport;
    typedef struct packed {
        logic       rd;
        logic [8:0] a;
        logic [7:0] d;
    } xfer_t;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b1;

    int    n_tests = 0;
    int    n_fail  = 0;
    string cur_test = "none";

    logic [7:0] m_mem [2][64];
    logic [7:0] exp_rdata;
    logic [7:0] obs_rdata;
    xfer_t      burst_q[$];

    apb_modport_if #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) bus ();

    apb_modport #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached in %s", cur_test);
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++)
                m_mem[s][i] = 8'h00;
        exp_rdata = 8'h00;
    endfunction

    function automatic void model_apply(input xfer_t x);
        if (x.a[7:6] != 2'b00) begin
            if (x.rd) exp_rdata = 8'h00;
        end else if (x.rd) begin
            exp_rdata = m_mem[x.a[8]][x.a[5:0]];
        end else begin
            m_mem[x.a[8]][x.a[5:0]] = x.d;
        end
    endfunction

    function automatic logic [8:0] rand_addr();
        logic [1:0] rng;
        rng = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
        return {1'($urandom_range(1)), rng, 6'($urandom_range(7))};
    endfunction

    task automatic drive_req(input xfer_t x);
        bus.transfer       = 1'b1;
        bus.READ_WRITE     = x.rd;
        bus.apb_write_data = x.d;
        if (x.rd) begin
            bus.apb_read_paddr  = x.a;
            bus.apb_write_paddr = 9'($urandom);
        end else begin
            bus.apb_write_paddr = x.a;
            bus.apb_read_paddr  = 9'($urandom);
        end
    endtask

    task automatic scramble(input logic keep_transfer);
        bus.transfer        = keep_transfer;
        bus.READ_WRITE      = 1'($urandom);
        bus.apb_write_paddr = 9'($urandom);
        bus.apb_read_paddr  = 9'($urandom);
        bus.apb_write_data  = 8'($urandom);
    endtask

    // One isolated transfer; caller is in the low clock phase, returns at the negedge after completion.
    task automatic xfer(input xfer_t x);
        logic err;
        err = (x.a[7:6] != 2'b00);
        drive_req(x);
        @(posedge PCLK); @(negedge PCLK);
        scramble(1'b0);
        n_tests++;
        if (bus.PSLVERR !== 1'b0) begin
            n_fail++;
            $display("FAIL %s setup_slverr addr=%h: got %b want 0", cur_test, x.a, bus.PSLVERR);
        end
        @(posedge PCLK); @(negedge PCLK);
        n_tests++;
        if (bus.PSLVERR !== err) begin
            n_fail++;
            $display("FAIL %s access_slverr addr=%h: got %b want %b", cur_test, x.a, bus.PSLVERR, err);
        end
        n_tests++;
        if (bus.apb_read_data_out !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s access_rdata_hold addr=%h: got %h want %h", cur_test, x.a, bus.apb_read_data_out, exp_rdata);
        end
        model_apply(x);
        @(posedge PCLK); @(negedge PCLK);
        n_tests++;
        if (bus.PSLVERR !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_slverr addr=%h: got %b want 0", cur_test, x.a, bus.PSLVERR);
        end
        n_tests++;
        if (bus.apb_read_data_out !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s result_rdata rd=%b addr=%h: got %h want %h", cur_test, x.rd, x.a, bus.apb_read_data_out, exp_rdata);
        end
        obs_rdata = bus.apb_read_data_out;
    endtask

    // Runs burst_q with transfer held high; each transfer must take exactly two cycles.
    task automatic burst();
        int    n;
        logic  err;
        n = burst_q.size();
        drive_req(burst_q[0]);
        for (int k = 0; k < n; k++) begin
            err = (burst_q[k].a[7:6] != 2'b00);
            @(posedge PCLK); @(negedge PCLK);
            scramble(1'b1);
            n_tests++;
            if (bus.PSLVERR !== 1'b0) begin
                n_fail++;
                $display("FAIL %s b2b_setup_slverr k=%0d: got %b want 0", cur_test, k, bus.PSLVERR);
            end
            n_tests++;
            if (bus.apb_read_data_out !== exp_rdata) begin
                n_fail++;
                $display("FAIL %s b2b_setup_rdata k=%0d: got %h want %h", cur_test, k, bus.apb_read_data_out, exp_rdata);
            end
            @(posedge PCLK); @(negedge PCLK);
            n_tests++;
            if (bus.PSLVERR !== err) begin
                n_fail++;
                $display("FAIL %s b2b_access_slverr k=%0d: got %b want %b", cur_test, k, bus.PSLVERR, err);
            end
            n_tests++;
            if (bus.apb_read_data_out !== exp_rdata) begin
                n_fail++;
                $display("FAIL %s b2b_access_rdata k=%0d: got %h want %h", cur_test, k, bus.apb_read_data_out, exp_rdata);
            end
            model_apply(burst_q[k]);
            if (k < n - 1) drive_req(burst_q[k + 1]);
            else           scramble(1'b0);
        end
        @(posedge PCLK); @(negedge PCLK);
        n_tests++;
        if (bus.apb_read_data_out !== exp_rdata || bus.PSLVERR !== 1'b0) begin
            n_fail++;
            $display("FAIL %s b2b_final: got rdata=%h slverr=%b want rdata=%h slverr=0", cur_test, bus.apb_read_data_out, bus.PSLVERR, exp_rdata);
        end
        obs_rdata = bus.apb_read_data_out;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        scramble(1'b0);
        model_clear();
        #1 PRESETn = 1'b0;
        #1;
        n_tests++;
        if (bus.apb_read_data_out !== 8'h00 || bus.PSLVERR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got rdata=%h slverr=%b want 00/0", bus.apb_read_data_out, bus.PSLVERR);
        end
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    task automatic test_basic();
        cur_test = "basic";
        xfer('{rd: 1'b1, a: 9'h005, d: 8'h00});
        n_tests++;
        if (obs_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL basic cleared_mem: got %h want 00", obs_rdata);
        end
        xfer('{rd: 1'b0, a: 9'h005, d: 8'hA5});
        xfer('{rd: 1'b1, a: 9'h005, d: 8'h00});
        n_tests++;
        if (obs_rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic read_005: got %h want a5", obs_rdata);
        end
    endtask

    task automatic test_isolation();
        cur_test = "isolation";
        xfer('{rd: 1'b0, a: 9'h105, d: 8'h3C});
        xfer('{rd: 1'b1, a: 9'h005, d: 8'h00});
        n_tests++;
        if (obs_rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL isolation read_005: got %h want a5", obs_rdata);
        end
        xfer('{rd: 1'b1, a: 9'h105, d: 8'h00});
        n_tests++;
        if (obs_rdata !== 8'h3C) begin
            n_fail++;
            $display("FAIL isolation read_105: got %h want 3c", obs_rdata);
        end
    endtask

    task automatic test_error();
        cur_test = "error_write";
        xfer('{rd: 1'b0, a: 9'h045, d: 8'h5A});
        xfer('{rd: 1'b1, a: 9'h005, d: 8'h00});
        n_tests++;
        if (obs_rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL error_write read_005: got %h want a5", obs_rdata);
        end
        cur_test = "error_read";
        xfer('{rd: 1'b1, a: 9'h0C0, d: 8'h00});
        n_tests++;
        if (obs_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL error_read read_0c0: got %h want 00", obs_rdata);
        end
    endtask

    task automatic test_back_to_back();
        cur_test = "back_to_back";
        burst_q = {};
        burst_q.push_back('{rd: 1'b0, a: 9'h012, d: 8'h11});
        burst_q.push_back('{rd: 1'b1, a: 9'h012, d: 8'h00});
        burst_q.push_back('{rd: 1'b0, a: 9'h113, d: 8'h22});
        burst_q.push_back('{rd: 1'b1, a: 9'h113, d: 8'h00});
        burst();
        n_tests++;
        if (obs_rdata !== 8'h22) begin
            n_fail++;
            $display("FAIL back_to_back last_read: got %h want 22", obs_rdata);
        end
    endtask

    task automatic test_random();
        cur_test = "random_single";
        for (int i = 0; i < 40; i++)
            xfer('{rd: 1'($urandom), a: rand_addr(), d: 8'($urandom)});
        cur_test = "random_burst";
        for (int b = 0; b < 6; b++) begin
            burst_q = {};
            for (int j = 0; j < int'($urandom_range(6, 2)); j++)
                burst_q.push_back('{rd: 1'($urandom), a: rand_addr(), d: 8'($urandom)});
            burst();
        end
    endtask

    task automatic test_reset_mid();
        cur_test = "reset_mid";
        xfer('{rd: 1'b0, a: 9'h007, d: 8'hC3});
        xfer('{rd: 1'b1, a: 9'h007, d: 8'h00});
        n_tests++;
        if (obs_rdata !== 8'hC3) begin
            n_fail++;
            $display("FAIL reset_mid pre_read: got %h want c3", obs_rdata);
        end
        drive_req('{rd: 1'b0, a: 9'h010, d: 8'h77});
        @(posedge PCLK); @(negedge PCLK);
        bus.transfer = 1'b0;
        @(posedge PCLK); @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        n_tests++;
        if (bus.apb_read_data_out !== 8'h00 || bus.PSLVERR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid async_outputs: got rdata=%h slverr=%b want 00/0", bus.apb_read_data_out, bus.PSLVERR);
        end
        model_clear();
        #1 PRESETn = 1'b1;
        xfer('{rd: 1'b1, a: 9'h010, d: 8'h00});
        n_tests++;
        if (obs_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid read_010: got %h want 00", obs_rdata);
        end
        xfer('{rd: 1'b1, a: 9'h007, d: 8'h00});
        n_tests++;
        if (obs_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid read_007: got %h want 00", obs_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_isolation();
        test_error();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
